// File: rtl/display_pixel_out_if.sv
// Pixel-stage bus: compositor/VGA-timing inputs, sprite-ROM port, VGA pins and fade status.
// The slave modport is the pixel output stage; the master side is its environment.
interface display_pixel_out_if;
  logic        pix_en;
  logic [9:0]  h_cnt;
  logic [9:0]  v_cnt;
  logic        valid;
  logic        hsync_in;
  logic        vsync_in;
  logic [16:0] pixel_addr;
  logic        notBlank;
  logic        isDark;
  logic [8:0]  player_x;
  logic [8:0]  player_y;
  logic        fade_start;
  logic [16:0] rom_addr;
  logic [11:0] rom_data;
  logic [3:0]  vgaRed;
  logic [3:0]  vgaGreen;
  logic [3:0]  vgaBlue;
  logic        hsync;
  logic        vsync;
  logic        fade_busy;

  modport slave (
    input  pix_en, h_cnt, v_cnt, valid, hsync_in, vsync_in, pixel_addr,
           notBlank, isDark, player_x, player_y, fade_start, rom_data,
    output rom_addr, vgaRed, vgaGreen, vgaBlue, hsync, vsync, fade_busy
  );

  modport master (
    output pix_en, h_cnt, v_cnt, valid, hsync_in, vsync_in, pixel_addr,
           notBlank, isDark, player_x, player_y, fade_start, rom_data,
    input  rom_addr, vgaRed, vgaGreen, vgaBlue, hsync, vsync, fade_busy
  );
endinterface

// File: rtl/display_pixel_out.sv
// Two-stage pixel output: ROM fetch, colour-key, dark-room spotlight and frame fade-in,
// with syncs delayed to leave on the same pixel tick as the colour.
//   state | meaning
//   IDLE  | no fade, level held at 15 (full brightness)
//   RUN   | fade in progress, level steps every FADE_DIV frames
module display_pixel_out #(
  parameter logic [11:0] KEY_COLOR = 12'hF0F,
  parameter int          SPOT_R    = 48,
  parameter int          FADE_DIV  = 4
) (
  input logic               clk,
  input logic               rst,
  display_pixel_out_if.slave pix_if
);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;
  localparam int FCW = (FADE_DIV > 1) ? $clog2(FADE_DIV) : 1;
  localparam logic [FCW-1:0] FCNT_LAST = FCW'(FADE_DIV - 1);
  localparam logic signed [10:0] SPOT_LIM = 11'(SPOT_R);

  // S0 registers
  logic [16:0] rom_addr_q;
  logic        valid_q, nb_q, hs_q, vs_q, spot_q;

  // S1 registers
  logic [3:0]  red_q, green_q, blue_q;
  logic        hsync_q, vsync_q;

  // Fade controller
  logic [0:0]     state_q, state_d;
  logic [3:0]     level_q, level_d;
  logic [FCW-1:0] fcnt_q, fcnt_d;

  logic signed [10:0] dx, dy, adx, ady;
  logic               spot_c;
  logic [11:0]        base_c;
  logic               dim_c;
  logic               vs_fall;

  function automatic logic [3:0] shade(input logic [3:0] c, input logic dim,
                                       input logic [3:0] lvl);
    logic [3:0] cd;
    logic [7:0] prod;
    cd   = dim ? (c >> 2) : c;
    prod = {4'b0000, cd} * ({4'b0000, lvl} + 8'd1);
    return prod[7:4];
  endfunction

  // Game-space distance; 11-bit signed so player near the edge never wraps.
  always_comb begin
    dx     = $signed({1'b0, pix_if.h_cnt} >> 1) - $signed({2'b00, pix_if.player_x});
    dy     = $signed({1'b0, pix_if.v_cnt} >> 1) - $signed({2'b00, pix_if.player_y});
    adx    = dx[10] ? -dx : dx;
    ady    = dy[10] ? -dy : dy;
    spot_c = (adx < SPOT_LIM) && (ady < SPOT_LIM);
  end

  always_comb begin
    base_c = (valid_q && nb_q && (pix_if.rom_data != KEY_COLOR)) ? pix_if.rom_data : 12'h000;
    dim_c  = pix_if.isDark && !spot_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rom_addr_q <= '0;
      valid_q    <= 1'b0;
      nb_q       <= 1'b0;
      spot_q     <= 1'b0;
      hs_q       <= 1'b1;
      vs_q       <= 1'b1;
      red_q      <= '0;
      green_q    <= '0;
      blue_q     <= '0;
      hsync_q    <= 1'b1;
      vsync_q    <= 1'b1;
    end else if (pix_if.pix_en) begin
      rom_addr_q <= pix_if.pixel_addr;
      valid_q    <= pix_if.valid;
      nb_q       <= pix_if.notBlank;
      spot_q     <= spot_c;
      hs_q       <= pix_if.hsync_in;
      vs_q       <= pix_if.vsync_in;
      red_q      <= shade(base_c[11:8], dim_c, level_q);
      green_q    <= shade(base_c[7:4],  dim_c, level_q);
      blue_q     <= shade(base_c[3:0],  dim_c, level_q);
      hsync_q    <= hs_q;
      vsync_q    <= vs_q;
    end
  end

  assign vs_fall = vs_q && !pix_if.vsync_in;

  // fade_start is taken on any clk and overrides a coincident frame step.
  always_comb begin
    state_d = state_q;
    level_d = level_q;
    fcnt_d  = fcnt_q;
    if (pix_if.fade_start) begin
      state_d = ST_RUN;
      level_d = 4'd0;
      fcnt_d  = '0;
    end else if (pix_if.pix_en && (state_q == ST_RUN) && vs_fall) begin
      if (fcnt_q == FCNT_LAST) begin
        fcnt_d = '0;
        if (level_q == 4'd15) begin
          state_d = ST_IDLE;
        end else begin
          level_d = level_q + 4'd1;
        end
      end else begin
        fcnt_d = fcnt_q + FCW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      level_q <= 4'd15;
      fcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      level_q <= level_d;
      fcnt_q  <= fcnt_d;
    end
  end

  assign pix_if.rom_addr  = rom_addr_q;
  assign pix_if.vgaRed    = red_q;
  assign pix_if.vgaGreen  = green_q;
  assign pix_if.vgaBlue   = blue_q;
  assign pix_if.hsync     = hsync_q;
  assign pix_if.vsync     = vsync_q;
  assign pix_if.fade_busy = (state_q == ST_RUN);

endmodule

// File: tb/tb_display_pixel_out.sv
// Randomised and directed bench for display_pixel_out against a frame/pixel-level model
// (pixel colour from game-space rules, fade level from counted vsync falls).
module tb_display_pixel_out;

  localparam logic [11:0] KEY  = 12'hF0F;
  localparam int          SPOT = 48;
  localparam int          FDIV = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  display_pixel_out_if dif();

  display_pixel_out #(.KEY_COLOR(KEY), .SPOT_R(SPOT), .FADE_DIV(FDIV)) dut (
    .clk    (clk),
    .rst    (rst),
    .pix_if (dif.slave)
  );

  logic [11:0] rom_mem [256];
  always @(posedge clk) dif.rom_data <= rom_mem[dif.rom_addr[7:0]];

  typedef struct {
    logic [16:0] addr;
    bit valid, nb, hs, vs;
    int h, v, px, py;
  } snap_t;

  int total = 0;
  int bad   = 0;

  snap_t       prev;
  bit          m_busy;
  int          m_edges;
  logic [11:0] exp_rgb;
  bit          exp_hs, exp_vs;

  function automatic logic [11:0] model_pix(snap_t s, logic [11:0] rom, bit dark, int lvl);
    int dx, dy, c;
    bit lit;
    logic [11:0] res;
    dx = s.h / 2 - s.px;
    dy = s.v / 2 - s.py;
    if (dx < 0) dx = -dx;
    if (dy < 0) dy = -dy;
    lit = (dx < SPOT) && (dy < SPOT);
    res = 12'h000;
    for (int i = 0; i < 3; i++) begin
      c = (s.valid && s.nb && rom != KEY) ? int'((rom >> (8 - 4 * i)) & 12'h00F) : 0;
      if (dark && !lit) c = c / 4;
      c = c * (lvl + 1) / 16;
      res = res | (12'(c) << (8 - 4 * i));
    end
    return res;
  endfunction

  function automatic logic [11:0] rgb();
    return {dif.vgaRed, dif.vgaGreen, dif.vgaBlue};
  endfunction

  task automatic model_reset();
    prev.addr = '0; prev.valid = 0; prev.nb = 0; prev.hs = 1; prev.vs = 1;
    prev.h = 0; prev.v = 0; prev.px = 0; prev.py = 0;
    m_busy = 0; m_edges = 0;
    exp_rgb = 12'h000; exp_hs = 1; exp_vs = 1;
  endtask

  task automatic set_px(bit v, bit nb, logic [16:0] a);
    dif.valid = v; dif.notBlank = nb; dif.pixel_addr = a;
  endtask

  // One pixel tick (4 clks); updates the model's expected outputs.
  task automatic step();
    snap_t cur;
    int lvl;
    cur.addr = dif.pixel_addr; cur.valid = dif.valid; cur.nb = dif.notBlank;
    cur.hs = dif.hsync_in; cur.vs = dif.vsync_in;
    cur.h = int'(dif.h_cnt); cur.v = int'(dif.v_cnt);
    cur.px = int'(dif.player_x); cur.py = int'(dif.player_y);
    @(negedge clk) dif.pix_en = 1'b1;
    @(negedge clk) dif.pix_en = 1'b0;
    lvl = m_busy ? m_edges / FDIV : 15;
    exp_rgb = model_pix(prev, rom_mem[prev.addr[7:0]], dif.isDark, lvl);
    exp_hs = prev.hs;
    exp_vs = prev.vs;
    if (m_busy && prev.vs && !cur.vs) begin
      m_edges++;
      if (m_edges == 16 * FDIV) m_busy = 0;
    end
    prev = cur;
    @(negedge clk);
    @(negedge clk);
  endtask

  task automatic pulse_start();
    @(negedge clk) dif.fade_start = 1'b1;
    @(negedge clk) dif.fade_start = 1'b0;
    m_busy = 1; m_edges = 0;
  endtask

  task automatic frame();
    dif.vsync_in = 1'b0; step();
    dif.vsync_in = 1'b1; step();
  endtask

  task automatic test_reset();
    dif.hsync_in = 1'b0; dif.vsync_in = 1'b0;
    set_px(1, 1, 17'd1);
    rst = 1'b1;
    for (int i = 0; i < 8; i++) @(negedge clk) dif.pix_en = ~dif.pix_en;
    @(negedge clk) dif.pix_en = 1'b0;
    total++; if (dif.hsync !== 1'b1 || dif.vsync !== 1'b1) begin
      bad++; $display("FAIL reset_sync got=%b%b exp=11", dif.hsync, dif.vsync); end
    total++; if (rgb() !== 12'h000) begin
      bad++; $display("FAIL reset_rgb got=%h exp=000", rgb()); end
    total++; if (dif.rom_addr !== 17'd0) begin
      bad++; $display("FAIL reset_rom_addr got=%h exp=0", dif.rom_addr); end
    total++; if (dif.fade_busy !== 1'b0) begin
      bad++; $display("FAIL reset_busy got=%b exp=0", dif.fade_busy); end
    rst = 1'b0;
    dif.hsync_in = 1'b1; dif.vsync_in = 1'b1;
    model_reset();
  endtask

  task automatic test_basic();
    set_px(1, 1, 17'd1);
    dif.hsync_in = 1'b0;
    step();
    total++; if (rgb() !== exp_rgb || rgb() !== 12'h000) begin
      bad++; $display("FAIL basic_lat1 got=%h exp=%h", rgb(), exp_rgb); end
    total++; if (dif.rom_addr !== 17'd1) begin
      bad++; $display("FAIL basic_rom_addr got=%h exp=1", dif.rom_addr); end
    dif.hsync_in = 1'b1;
    step();
    total++; if (rgb() !== exp_rgb || rgb() !== 12'h5A3) begin
      bad++; $display("FAIL basic_rgb got=%h exp=5a3 model=%h", rgb(), exp_rgb); end
    total++; if (dif.hsync !== exp_hs || dif.hsync !== 1'b0) begin
      bad++; $display("FAIL basic_hsync got=%b exp=0", dif.hsync); end
    step();
    total++; if (dif.hsync !== 1'b1) begin
      bad++; $display("FAIL basic_hsync_rel got=%b exp=1", dif.hsync); end
  endtask

  task automatic test_key();
    bit          v_t  [4] = '{1, 1, 0, 1};
    bit          nb_t [4] = '{1, 0, 1, 1};
    logic [16:0] a_t  [4] = '{17'd2, 17'd3, 17'd3, 17'd3};
    for (int i = 0; i < 4; i++) begin
      set_px(v_t[i], nb_t[i], a_t[i]);
      step();
      if (i >= 1) begin
        total++; if (rgb() !== exp_rgb || rgb() !== 12'h000) begin
          bad++; $display("FAIL key_case%0d got=%h exp=000", i - 1, rgb()); end
      end
    end
  endtask

  task automatic test_dark();
    int          h_t [6] = '{200, 400, 295, 296, 0, 0};
    int          p_t [6] = '{100, 100, 100, 100, 0, 0};
    logic [11:0] e_t [5] = '{12'hFFF, 12'h333, 12'hFFF, 12'h333, 12'hFFF};
    dif.isDark = 1'b1; dif.player_y = 9'd100; dif.v_cnt = 10'd200;
    set_px(1, 1, 17'd3);
    for (int i = 0; i < 6; i++) begin
      dif.h_cnt = 10'(h_t[i]); dif.player_x = 9'(p_t[i]);
      step();
      if (i >= 1) begin
        total++; if (rgb() !== exp_rgb || rgb() !== e_t[i - 1]) begin
          bad++; $display("FAIL dark_case%0d got=%h exp=%h", i - 1, rgb(), e_t[i - 1]); end
      end
    end
    dif.isDark = 1'b0;
  endtask

  task automatic test_fade();
    set_px(1, 1, 17'd3);
    dif.vsync_in = 1'b1;
    pulse_start();
    step();
    total++; if (rgb() !== exp_rgb || rgb() !== 12'h000) begin
      bad++; $display("FAIL fade_lvl0 got=%h exp=000", rgb()); end
    total++; if (dif.fade_busy !== 1'b1) begin
      bad++; $display("FAIL fade_busy_on got=%b exp=1", dif.fade_busy); end
    for (int e = 1; e <= 64; e++) begin
      frame();
      total++; if (rgb() !== exp_rgb || dif.fade_busy !== m_busy) begin
        bad++; $display("FAIL fade_frame%0d got=%h/%b exp=%h/%b", e, rgb(), dif.fade_busy, exp_rgb, m_busy); end
      if (e == 4) begin
        total++; if (rgb() !== 12'h111) begin
          bad++; $display("FAIL fade_lvl1 got=%h exp=111", rgb()); end
      end
    end
    total++; if (dif.fade_busy !== 1'b0 || rgb() !== 12'hFFF) begin
      bad++; $display("FAIL fade_done got=%b/%h exp=0/fff", dif.fade_busy, rgb()); end
  endtask

  task automatic test_restart();
    set_px(1, 1, 17'd3);
    pulse_start();
    for (int e = 0; e < 28; e++) frame();
    total++; if (rgb() !== exp_rgb || rgb() !== 12'h777) begin
      bad++; $display("FAIL restart_lvl7 got=%h exp=777", rgb()); end
    pulse_start();
    total++; if (dif.fade_busy !== 1'b1) begin
      bad++; $display("FAIL restart_busy got=%b exp=1", dif.fade_busy); end
    step();
    total++; if (rgb() !== exp_rgb || rgb() !== 12'h000) begin
      bad++; $display("FAIL restart_lvl0 got=%h exp=000", rgb()); end
    frame(); frame();
    @(negedge clk) rst = 1'b1;
    @(negedge clk) rst = 1'b0;
    model_reset();
    total++; if (dif.fade_busy !== 1'b0 || rgb() !== 12'h000) begin
      bad++; $display("FAIL midreset got=%b/%h exp=0/000", dif.fade_busy, rgb()); end
    step(); step();
    total++; if (rgb() !== exp_rgb || rgb() !== 12'hFFF) begin
      bad++; $display("FAIL midreset_lvl15 got=%h exp=fff", rgb()); end
  endtask

  task automatic test_hold();
    set_px(1, 1, 17'd1);
    step(); step();
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      set_px(1'($urandom), 1'($urandom), 17'($urandom));
      dif.h_cnt = 10'($urandom_range(0, 639)); dif.isDark = 1'($urandom);
      dif.hsync_in = 1'($urandom); dif.vsync_in = 1'($urandom);
      total++; if (rgb() !== exp_rgb || dif.rom_addr !== prev.addr || dif.hsync !== exp_hs) begin
        bad++; $display("FAIL hold_clk%0d got=%h/%h/%b exp=%h/%h/%b", i, rgb(), dif.rom_addr,
                        dif.hsync, exp_rgb, prev.addr, exp_hs); end
    end
    dif.isDark = 1'b0;
  endtask

  task automatic test_random();
    int px, h;
    for (int n = 0; n < 300; n++) begin
      px = $urandom_range(0, 319);
      h  = 2 * px + $urandom_range(0, 240) - 120;
      if (h < 0) h = 0;
      if (h > 639) h = 639;
      set_px(($urandom % 4) != 0, ($urandom % 4) != 0, 17'($urandom));
      dif.player_x = 9'(px); dif.h_cnt = 10'(h);
      dif.player_y = 9'($urandom_range(0, 239)); dif.v_cnt = 10'($urandom_range(0, 479));
      dif.isDark = 1'($urandom); dif.hsync_in = 1'($urandom); dif.vsync_in = 1'($urandom);
      if (($urandom % 60) == 0) pulse_start();
      step();
      total++; if (rgb() !== exp_rgb || dif.hsync !== exp_hs || dif.vsync !== exp_vs
                   || dif.rom_addr !== prev.addr || dif.fade_busy !== m_busy) begin
        bad++; $display("FAIL random_step%0d got=%h %b%b %h %b exp=%h %b%b %h %b", n, rgb(),
                        dif.hsync, dif.vsync, dif.rom_addr, dif.fade_busy, exp_rgb,
                        exp_hs, exp_vs, prev.addr, m_busy); end
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) rom_mem[i] = 12'($urandom);
    for (int i = 0; i < 256; i += 17) rom_mem[i] = KEY;
    rom_mem[1] = 12'h5A3; rom_mem[2] = KEY; rom_mem[3] = 12'hFFF;
    dif.pix_en = 1'b0; dif.fade_start = 1'b0; dif.isDark = 1'b0;
    dif.h_cnt = '0; dif.v_cnt = '0; dif.player_x = '0; dif.player_y = '0;
    set_px(0, 0, '0);
    dif.hsync_in = 1'b1; dif.vsync_in = 1'b1;
    model_reset();
    test_reset();
    test_basic();
    test_key();
    test_dark();
    test_fade();
    test_restart();
    test_hold();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
